dptr_datapath: RTL and testbench

DPTR_DATAPATH -- requirements
Module: dptr_datapath

---
 rtl/dptr_pkg.sv | 27 ++
 rtl/dptr_if.sv | 8 +
 rtl/dptr_regfile.sv | 34 +++
 rtl/dptr_datapath.sv | 90 +++++++++
 tb/tb_dptr_datapath.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/dptr_pkg.sv
// Shared constants and types for the single-cycle datapath: opcodes, funct codes, ALU operations.
package dptr_pkg;

  localparam int unsigned RegIdxW = 5;
  localparam int unsigned NumRegs = 1 << RegIdxW;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    AluNop,
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluNor,
    AluSlt
  } alu_op_e;

endpackage

// File: rtl/dptr_if.sv
// Instruction/flag bus between the instruction driver and the datapath.
interface dptr_if;
  logic [31:0] Instr;
  logic        ZF;

  modport master (output Instr, input ZF);
  modport slave  (input Instr, output ZF);
endinterface

// File: rtl/dptr_regfile.sv
// 32-entry register file: two combinational read ports, one clocked write port, async clear.
module dptr_regfile
  import dptr_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RegIdxW-1:0] raddr_a,
  input  logic [RegIdxW-1:0] raddr_b,
  output logic [DATA_W-1:0]  rdata_a,
  output logic [DATA_W-1:0]  rdata_b,
  input  logic               we,
  input  logic [RegIdxW-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata
);

  logic [DATA_W-1:0] regs_q [NumRegs];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Reads see pre-edge contents; no bypass from the write port.
  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/dptr_datapath.sv
// Single-cycle datapath: decode, ALU and zero flag; executes the held instruction on every edge.
module dptr_datapath
  import dptr_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input logic    clk,
  input logic    rst,
  dptr_if.slave  bus
);

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [RegIdxW-1:0] rs;
  logic [RegIdxW-1:0] rt;
  logic [RegIdxW-1:0] rd;
  logic [15:0]        imm;
  logic [DATA_W-1:0]  imm_sext;

  assign op       = bus.Instr[31:26];
  assign rs       = bus.Instr[25:21];
  assign rt       = bus.Instr[20:16];
  assign rd       = bus.Instr[15:11];
  assign funct    = bus.Instr[5:0];
  assign imm      = bus.Instr[15:0];
  assign imm_sext = {{(DATA_W - 16){imm[15]}}, imm};

  alu_op_e            alu_op;
  logic               is_addi;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic [DATA_W-1:0]  opnd_b;
  logic [DATA_W-1:0]  result;
  logic               we;
  logic [RegIdxW-1:0] waddr;

  always_comb begin
    alu_op  = AluNop;
    is_addi = 1'b0;
    if (op == OpRtype) begin
      case (funct)
        FnAdd:   alu_op = AluAdd;
        FnSub:   alu_op = AluSub;
        FnAnd:   alu_op = AluAnd;
        FnOr:    alu_op = AluOr;
        FnNor:   alu_op = AluNor;
        FnSlt:   alu_op = AluSlt;
        default: alu_op = AluNop;
      endcase
    end else if (op == OpAddi) begin
      alu_op  = AluAdd;
      is_addi = 1'b1;
    end
  end

  assign opnd_b = is_addi ? imm_sext : rt_data;

  always_comb begin
    result = '0;
    case (alu_op)
      AluAdd:  result = rs_data + opnd_b;
      AluSub:  result = rs_data - opnd_b;
      AluAnd:  result = rs_data & opnd_b;
      AluOr:   result = rs_data | opnd_b;
      AluNor:  result = ~(rs_data | opnd_b);
      AluSlt:  result = {{(DATA_W - 1){1'b0}}, ($signed(rs_data) < $signed(opnd_b))};
      default: result = '0;
    endcase
  end

  // Unsupported encodings decode to AluNop and so never write.
  assign we     = (alu_op != AluNop);
  assign waddr  = is_addi ? rt : rd;
  assign bus.ZF = (result == '0);

  dptr_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .we      (we),
    .waddr   (waddr),
    .wdata   (result)
  );

endmodule

// File: tb/tb_dptr_datapath.sv
// Directed bench for dptr_datapath: checks ZF and register contents after hand-computed steps.
module tb_dptr_datapath;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  dptr_if bus ();

  dptr_datapath #(
    .DATA_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.Instr = rtype(5'd0, 5'd0, 5'd3, 6'h20);
    tick();
    chk("rst_r3", dut.u_regfile.regs_q[3], 32'h0);
    chk("rst_zf", bus.ZF, 1'b1);
    #3 rst = 1'b0;

    // ADD r3,r0,r0
    #1 chk("add_zero_zf", bus.ZF, 1'b1);
    tick();
    chk("add_zero_r3", dut.u_regfile.regs_q[3], 32'h0);

    // ADDI r1,r0,5 for one edge
    bus.Instr = addi(5'd0, 5'd1, 16'd5);
    #1 chk("addi5_zf", bus.ZF, 1'b0);
    tick();
    chk("addi5_r1", dut.u_regfile.regs_q[1], 32'd5);

    bus.Instr = rtype(5'd1, 5'd1, 5'd2, 6'h22);
    #1 chk("sub_zf", bus.ZF, 1'b1);
    tick();
    chk("sub_r2", dut.u_regfile.regs_q[2], 32'd0);

    bus.Instr = rtype(5'd1, 5'd1, 5'd2, 6'h20);
    #1 chk("add10_zf", bus.ZF, 1'b0);
    tick();
    chk("add10_r2", dut.u_regfile.regs_q[2], 32'd10);

    // Held self-increment: each edge reads the old value
    bus.Instr = addi(5'd9, 5'd9, 16'd1);
    tick();
    tick();
    tick();
    chk("repeat_r9", dut.u_regfile.regs_q[9], 32'd3);

    bus.Instr = addi(5'd0, 5'd4, 16'hFFFF);
    tick();
    chk("addim1_r4", dut.u_regfile.regs_q[4], 32'hFFFF_FFFF);

    bus.Instr = rtype(5'd4, 5'd0, 5'd5, 6'h2A);
    #1 chk("slt_neg_zf", bus.ZF, 1'b0);
    tick();
    chk("slt_neg_r5", dut.u_regfile.regs_q[5], 32'd1);

    bus.Instr = rtype(5'd0, 5'd4, 5'd5, 6'h2A);
    #1 chk("slt_pos_zf", bus.ZF, 1'b1);
    tick();
    chk("slt_pos_r5", dut.u_regfile.regs_q[5], 32'd0);

    bus.Instr = rtype(5'd4, 5'd1, 5'd10, 6'h24);
    tick();
    chk("and_r10", dut.u_regfile.regs_q[10], 32'd5);

    bus.Instr = rtype(5'd4, 5'd0, 5'd11, 6'h27);
    #1 chk("nor_zf", bus.ZF, 1'b1);
    bus.Instr = rtype(5'd1, 5'd0, 5'd11, 6'h27);
    tick();
    chk("nor_r11", dut.u_regfile.regs_q[11], 32'hFFFF_FFFA);

    bus.Instr = rtype(5'd2, 5'd1, 5'd13, 6'h25);
    tick();
    chk("or_r13", dut.u_regfile.regs_q[13], 32'd15);

    // Write to r0 is discarded
    bus.Instr = addi(5'd0, 5'd0, 16'd7);
    #1 chk("addi_r0_zf", bus.ZF, 1'b0);
    tick();
    bus.Instr = rtype(5'd0, 5'd0, 5'd6, 6'h25);
    #1 chk("or_r0_zf", bus.ZF, 1'b1);
    tick();
    chk("or_r0_r6", dut.u_regfile.regs_q[6], 32'd0);

    // Unsupported funct and op: result 0, no write
    bus.Instr = rtype(5'd1, 5'd1, 5'd12, 6'h3F);
    #1 chk("badfn_zf", bus.ZF, 1'b1);
    tick();
    chk("badfn_r12", dut.u_regfile.regs_q[12], 32'd0);
    chk("badfn_r1", dut.u_regfile.regs_q[1], 32'd5);
    bus.Instr = {6'h3F, 5'd1, 5'd1, 16'd0};
    #1 chk("badop_zf", bus.ZF, 1'b1);
    tick();
    chk("badop_r1", dut.u_regfile.regs_q[1], 32'd5);

    // Asynchronous reset between edges
    bus.Instr = rtype(5'd1, 5'd1, 5'd7, 6'h20);
    #1 chk("pre_rst_zf", bus.ZF, 1'b0);
    #1 rst = 1'b1;
    #1 chk("async_rst_r1", dut.u_regfile.regs_q[1], 32'd0);
    chk("async_rst_zf", bus.ZF, 1'b1);
    chk("async_rst_r4", dut.u_regfile.regs_q[4], 32'd0);
    tick();
    chk("rst_hold_r7", dut.u_regfile.regs_q[7], 32'd0);
    #2 rst = 1'b0;

    bus.Instr = addi(5'd0, 5'd1, 16'd5);
    tick();
    chk("resume_r1", dut.u_regfile.regs_q[1], 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
